// File: rtl/execute_stage.sv
// execute_stage: MIPS EX stage with ALU, branch target, destination select,
// EX/MEM pipeline register and an iterative 32-cycle multiply/divide unit.
module execute_stage #(
    parameter int unsigned len = 32,
    parameter int unsigned NB  = $clog2(len)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [len-1:0] in_pc,
    input  logic [len-1:0] in_reg_a,
    input  logic [len-1:0] in_reg_b,
    input  logic [len-1:0] in_sign_extend,
    input  logic [NB-1:0]  in_rt,
    input  logic [NB-1:0]  in_rd,
    input  logic [6:0]     execute_bus,
    input  logic [7:0]     in_memory_bus,
    input  logic [1:0]     in_writeBack_bus,
    output logic [len-1:0] out_addr_mem,
    output logic [len-1:0] out_write_data,
    output logic [7:0]     out_memory_bus,
    output logic [1:0]     out_writeBack_bus,
    output logic [NB-1:0]  out_write_reg,
    output logic           out_zero_flag,
    output logic [len-1:0] out_pc_branch,
    output logic           stall
);
    localparam int unsigned CW = $clog2(len);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_SLT   = 5'd6;
    localparam logic [4:0] OP_SLTU  = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_LUI   = 5'd11;
    localparam logic [4:0] OP_MULT  = 5'd12;
    localparam logic [4:0] OP_MULTU = 5'd13;
    localparam logic [4:0] OP_DIV   = 5'd14;
    localparam logic [4:0] OP_DIVU  = 5'd15;
    localparam logic [4:0] OP_MFHI  = 5'd16;
    localparam logic [4:0] OP_MFLO  = 5'd17;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [len-1:0]     hi_q, lo_q;
    logic [2*len-1:0]   acc_q;
    logic [len-1:0]     opnd_q;
    logic [len-1:0]     dividend_q;
    logic               is_div_q, neg_res_q, neg_rem_q, div_zero_q;

    logic               alu_src, reg_dst;
    logic [4:0]         alu_op;
    logic [4:0]         shamt;
    logic [len-1:0]     op_b;
    logic [NB-1:0]      dest;
    logic [len-1:0]     result;
    logic               is_md, is_signed_md, is_div_op;
    logic               a_neg, b_neg;
    logic [len-1:0]     mag_a, mag_b;

    logic [len:0]       mul_sum;
    logic [len:0]       div_shift, div_diff;
    logic               div_ge;
    logic [2*len-1:0]   step;
    logic [2*len-1:0]   prod;
    logic [len-1:0]     quot_fix, rem_fix;
    logic [len-1:0]     hi_fin, lo_fin;

    assign alu_src = execute_bus[0];
    assign reg_dst = execute_bus[1];
    assign alu_op  = execute_bus[6:2];
    assign shamt   = in_sign_extend[10:6];
    assign op_b    = alu_src ? in_sign_extend : in_reg_b;
    assign dest    = reg_dst ? in_rd : in_rt;

    assign is_md        = (alu_op >= OP_MULT) && (alu_op <= OP_DIVU);
    assign is_signed_md = (alu_op == OP_MULT) || (alu_op == OP_DIV);
    assign is_div_op    = (alu_op == OP_DIV) || (alu_op == OP_DIVU);
    assign a_neg        = is_signed_md & in_reg_a[len-1];
    assign b_neg        = is_signed_md & op_b[len-1];
    assign mag_a        = a_neg ? -in_reg_a : in_reg_a;
    assign mag_b        = b_neg ? -op_b : op_b;

    // Upstream holds while a mul/div is starting or iterating; DONE releases it.
    assign stall = ((state_q == S_IDLE) && is_md) || (state_q == S_RUN);

    // Single-cycle ALU.
    always_comb begin
        result = '0;
        case (alu_op)
            OP_ADD:  result = in_reg_a + op_b;
            OP_SUB:  result = in_reg_a - op_b;
            OP_AND:  result = in_reg_a & op_b;
            OP_OR:   result = in_reg_a | op_b;
            OP_XOR:  result = in_reg_a ^ op_b;
            OP_NOR:  result = ~(in_reg_a | op_b);
            OP_SLT:  result = len'($signed(in_reg_a) < $signed(op_b));
            OP_SLTU: result = len'(in_reg_a < op_b);
            OP_SLL:  result = op_b << shamt;
            OP_SRL:  result = op_b >> shamt;
            OP_SRA:  result = $unsigned($signed(op_b) >>> shamt);
            OP_LUI:  result = len'({op_b[15:0], 16'h0000});
            OP_MFHI: result = hi_q;
            OP_MFLO: result = lo_q;
            default: result = '0;
        endcase
    end

    // One shift-add (multiply) or restoring-subtract (divide) iteration over
    // acc_q, plus sign correction of the result of the final iteration.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*len-1:len]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*len-1:len], acc_q[len-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = div_shift >= {1'b0, opnd_q};
        if (is_div_q) begin
            step = {(div_ge ? div_diff[len-1:0] : div_shift[len-1:0]),
                    acc_q[len-2:0], div_ge};
        end else begin
            step = {mul_sum, acc_q[len-1:1]};
        end
        prod     = neg_res_q ? -step : step;
        quot_fix = neg_res_q ? -step[len-1:0] : step[len-1:0];
        rem_fix  = neg_rem_q ? -step[2*len-1:len] : step[2*len-1:len];
        if (is_div_q && div_zero_q) begin
            hi_fin = dividend_q;
            lo_fin = '1;
        end else if (is_div_q) begin
            hi_fin = rem_fix;
            lo_fin = quot_fix;
        end else begin
            hi_fin = prod[2*len-1:len];
            lo_fin = prod[len-1:0];
        end
    end

    // Mul/div sequencer and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            dividend_q <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_md) begin
                        state_q    <= S_RUN;
                        cnt_q      <= '0;
                        is_div_q   <= is_div_op;
                        opnd_q     <= is_div_op ? mag_b : mag_a;
                        acc_q      <= {{len{1'b0}}, (is_div_op ? mag_a : mag_b)};
                        dividend_q <= in_reg_a;
                        neg_res_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        div_zero_q <= (op_b == '0);
                    end
                end
                S_RUN: begin
                    acc_q <= step;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(len - 1)) begin
                        hi_q    <= hi_fin;
                        lo_q    <= lo_fin;
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // EX/MEM pipeline register; stalls and mul/div ops insert a bubble.
    always_ff @(posedge clk) begin
        if (reset || stall || is_md) begin
            out_addr_mem      <= '0;
            out_write_data    <= '0;
            out_memory_bus    <= '0;
            out_writeBack_bus <= '0;
            out_write_reg     <= '0;
            out_zero_flag     <= 1'b0;
            out_pc_branch     <= '0;
        end else begin
            out_addr_mem      <= result;
            out_write_data    <= in_reg_b;
            out_memory_bus    <= in_memory_bus;
            out_writeBack_bus <= in_writeBack_bus;
            out_write_reg     <= dest;
            out_zero_flag     <= (result == '0);
            out_pc_branch     <= in_pc + (in_sign_extend << 2);
        end
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

EX stage of the 5-stage MIPS pipeline, directly upstream of the memory stage. Performs ALU operations, computes the branch target and zero flag, selects the destination register, and registers everything into the EX/MEM pipeline register that the memory stage consumes. Contains an iterative 32-cycle multiply/divide unit with HI/LO registers, and stalls the upstream stages while it runs.

## Interface
- len, 32, datapath width
- NB, $clog2(len), register-index width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_pc  in  len  PC+4 of the instruction in EX
- in_reg_a  in  len  rs operand
- in_reg_b  in  len  rt operand; also the store data
- in_sign_extend  in  len  sign-extended immediate; [10:6] is shamt
- in_rt  in  NB  rt index
- in_rd  in  NB  rd index
- execute_bus  in  7  [0] ALUSrc, [1] RegDst, [6:2] alu_op
- in_memory_bus  in  8  memory-stage control, passed through
- in_writeBack_bus  in  2  write-back control, passed through
- out_addr_mem  out  len  registered ALU result
- out_write_data  out  len  registered in_reg_b
- out_memory_bus  out  8  registered
- out_writeBack_bus  out  2  registered
- out_write_reg  out  NB  registered destination index
- out_zero_flag  out  1  registered (ALU result == 0)
- out_pc_branch  out  len  registered in_pc + (in_sign_extend << 2)
- stall  out  1  combinational; upstream holds IF/ID/EX inputs while high

## Operation
- Operand B = ALUSrc ? in_sign_extend : in_reg_b. Destination = RegDst ? in_rd : in_rt.
- alu_op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA (shifts apply to B by shamt), 11 LUI ({B[15:0],16'h0}), 12 MULT, 13 MULTU, 14 DIV, 15 DIVU, 16 MFHI, 17 MFLO. Codes 18-31 produce result 0.
- ADD/SUB wrap modulo 2^len; no overflow exception.
- MULT/MULTU: 64-bit product, HI = upper, LO = lower. Shift-add over magnitudes; for signed ops, negate the 64-bit result when the operand signs differ.
- DIV/DIVU: restoring division over magnitudes; LO = quotient, HI = remainder. Signed: quotient is negative when signs differ; remainder takes the dividend's sign. Divide by zero: LO = 32'hFFFFFFFF, HI = in_reg_a unchanged (signed or unsigned).
- Mul/div instructions write no GPR. They enter EX/MEM as a bubble: out_memory_bus = 0 and out_writeBack_bus = 0.
- MFHI/MFLO read HI/LO. If a mul/div is in progress, they are held by stall until it completes.
- FSM states:
  - IDLE: a mul/div op present → stall = 1, latch operands and op, go to RUN with cnt = 0.
  - RUN: stall = 1, one iteration per cycle, cnt increments. At cnt == 31, HI/LO are written at that edge and the FSM goes to DONE.
  - DONE: stall = 0, EX/MEM captures the bubble, next state IDLE. A mul/div op still on the inputs in DONE does not restart the unit.
- While stall = 1, the EX/MEM register loads a bubble (all outputs 0) and HI/LO are unchanged except at the final RUN edge.

## Timing
- Non-mul/div ops: 1-cycle latency, inputs at edge n appear on outputs after edge n.
- Mul/div arriving in cycle t (state IDLE):
  - stall is high in cycles t..t+32 (33 cycles).
  - HI/LO are valid from cycle t+33.
  - The next instruction enters EX in cycle t+34.
- MFHI immediately following a mul/div reads the new HI with no extra stall beyond the 33 cycles.
- Reset (including mid-RUN) at edge: state IDLE, cnt 0, HI = LO = 0, all out_* = 0. stall = 0 in the following cycle unless a mul/div op is present.
- reset overrides stall and all other inputs.

## Test plan
- ADD: in_reg_a = 5, in_reg_b = 7, ALUSrc = 0, RegDst = 1, in_rd = 3 → next cycle out_addr_mem = 12, out_write_reg = 3, out_zero_flag = 0.
- SUB for BEQ: a = b = 32'h1234, in_pc = 32'h100, in_sign_extend = 32'hFFFFFFFE → out_zero_flag = 1, out_pc_branch = 32'hF8.
- MULT: a = -3, b = 7 → stall high for exactly 33 cycles, then HI = 32'hFFFFFFFF and LO = 32'hFFFFFFEB. A following MFLO returns 32'hFFFFFFEB.
- DIV: a = -7, b = 2 → LO = 32'hFFFFFFFD (-3), HI = 32'hFFFFFFFF (-1). DIVU by 0 with a = 9 → LO = 32'hFFFFFFFF, HI = 9.
- Reset asserted at RUN cnt = 10 → next cycle all outputs 0, HI = LO = 0, stall = 0. A subsequent MFHI returns 0.
- SRA: b = 32'h80000000, shamt = 4 → 32'hF8000000. SLTU with a = 1, b = 32'hFFFFFFFF → 1. SLT with the same operands → 0.
